// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types: memory control word, sequencer states, byte-enable constants
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Memory-stage control field produced by decode.
    typedef struct packed {
        logic memRead;
        logic memWrite;
        logic dataMuxSel;
        logic byteEnable;
        logic indirect;
    } lc3b_mem_control;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        DATA = 2'd2
    } lc3b_mem_seq_state;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// rtl/mem_access_sequencer_if.sv - D-cache request/acknowledge bus
// Signals: oDMemRead/oDMemWrite/oDMemAddr/oDMemWdata/oDMemByteEn (sequencer -> cache),
//          iDMemResp/iDMemRdata (cache -> sequencer). master = sequencer, slave = cache.
interface mem_access_sequencer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  oDMemRead;
    logic                  oDMemWrite;
    logic [ADDR_WIDTH-1:0] oDMemAddr;
    logic [ADDR_WIDTH-1:0] oDMemWdata;
    logic [1:0]            oDMemByteEn;
    logic                  iDMemResp;
    logic [ADDR_WIDTH-1:0] iDMemRdata;

    modport master (
        output oDMemRead, oDMemWrite, oDMemAddr, oDMemWdata, oDMemByteEn,
        input  iDMemResp, iDMemRdata
    );

    modport slave (
        input  oDMemRead, oDMemWrite, oDMemAddr, oDMemWdata, oDMemByteEn,
        output iDMemResp, iDMemRdata
    );
endinterface

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - byte-lane enables, store-byte replication and load-byte extraction
// Inputs: addrLsb, byteEnable, storeData, readData. Outputs: byteEn, writeData, loadData.
module mem_byte_lane
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             addrLsb,
    input  logic             byteEnable,
    input  logic [WIDTH-1:0] storeData,
    input  logic [WIDTH-1:0] readData,
    output logic [1:0]       byteEn,
    output logic [WIDTH-1:0] writeData,
    output logic [WIDTH-1:0] loadData
);
    always_comb begin
        byteEn    = BE_WORD;
        writeData = storeData;
        loadData  = readData;
        if (byteEnable) begin
            byteEn = addrLsb ? BE_HI : BE_LO;
            // The store byte goes on both lanes so the enable alone picks the target.
            writeData = WIDTH'({storeData[7:0], storeData[7:0]});
            loadData  = addrLsb ? {{(WIDTH-8){1'b0}}, readData[15:8]}
                                : {{(WIDTH-8){1'b0}}, readData[7:0]};
        end
    end
endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - MEM-stage sequencer for direct and indirect D-cache accesses
// Ports: iClk, iResetN (async active-low), iValid, iMemControl, iAddress, iStoreData,
//        oBusy (stall), oDone (final ack pulse), oLoadData, dMem (D-cache bus, master).
// Option: MEM_SEQ_INDIRECT_EN enables the PTR state for two-access LDI/STI.
module mem_access_sequencer
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    iClk,
    input  logic                    iResetN,
    input  logic                    iValid,
    input  lc3b_mem_control         iMemControl,
    input  logic [ADDR_WIDTH-1:0]   iAddress,
    input  logic [ADDR_WIDTH-1:0]   iStoreData,
    output logic                    oBusy,
    output logic                    oDone,
    output logic [ADDR_WIDTH-1:0]   oLoadData,
    mem_access_sequencer_if.master  dMem
);
    lc3b_mem_seq_state      state;
    logic                   isWrite;
    logic                   isByte;
    logic [ADDR_WIDTH-1:0]  addrReg;   // doubles as the pointer register after PTR
    logic [ADDR_WIDTH-1:0]  storeReg;

    logic                   accept;
    logic                   inPtr;
    logic                   inData;
    logic [1:0]             laneBe;
    logic [ADDR_WIDTH-1:0]  laneWdata;
    logic [ADDR_WIDTH-1:0]  laneLoad;
    logic [ADDR_WIDTH-1:0]  wordAddr;
    logic                   unusedCtrl;

    assign accept     = iValid & (iMemControl.memRead | iMemControl.memWrite);
    assign unusedCtrl = ^{iMemControl.dataMuxSel, iMemControl.indirect};

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            state    <= IDLE;
            isWrite  <= 1'b0;
            isByte   <= 1'b0;
            addrReg  <= '0;
            storeReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Read wins when both request bits are set.
                        isWrite  <= iMemControl.memWrite & ~iMemControl.memRead;
                        isByte   <= iMemControl.byteEnable;
                        addrReg  <= iAddress;
                        storeReg <= iStoreData;
`ifdef MEM_SEQ_INDIRECT_EN
                        state    <= iMemControl.indirect ? PTR : DATA;
`else
                        state    <= DATA;
`endif
                    end
                end
`ifdef MEM_SEQ_INDIRECT_EN
                PTR: begin
                    if (dMem.iDMemResp) begin
                        addrReg <= dMem.iDMemRdata;
                        state   <= DATA;
                    end
                end
`endif
                DATA: begin
                    if (dMem.iDMemResp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_byte_lane #(
        .WIDTH(ADDR_WIDTH)
    ) u_lane (
        .addrLsb    (addrReg[0]),
        .byteEnable (isByte),
        .storeData  (storeReg),
        .readData   (dMem.iDMemRdata),
        .byteEn     (laneBe),
        .writeData  (laneWdata),
        .loadData   (laneLoad)
    );

    assign inPtr    = (state == PTR);
    assign inData   = (state == DATA);
    assign wordAddr = {addrReg[ADDR_WIDTH-1:1], 1'b0};

    // Request outputs decode only registered state, so reset drops them at once.
    assign dMem.oDMemRead   = inPtr | (inData & ~isWrite);
    assign dMem.oDMemWrite  = inData & isWrite;
    assign dMem.oDMemAddr   = inPtr  ? wordAddr :
                              inData ? (isByte ? addrReg : wordAddr) : '0;
    assign dMem.oDMemByteEn = inPtr ? BE_WORD : (inData ? laneBe : 2'b00);
    assign dMem.oDMemWdata  = (inData & isWrite) ? laneWdata : '0;

    assign oDone     = inData & dMem.iDMemResp;
    assign oLoadData = (oDone & ~isWrite) ? laneLoad : '0;
    assign oBusy     = ((state == IDLE) & accept) | inPtr | (inData & ~dMem.iDMemResp);
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - scoreboard bench for mem_access_sequencer
module tb_mem_access_sequencer;
    import lc3b_types::*;

    typedef struct {
        logic [15:0] addr;
        logic        write;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          waits;
        logic        isLast;
        logic [15:0] load;
    } acc_t;

    logic            iClk = 1'b0;
    logic            iResetN;
    logic            iValid;
    lc3b_mem_control iMemControl;
    logic [15:0]     iAddress;
    logic [15:0]     iStoreData;
    logic            oBusy;
    logic            oDone;
    logic [15:0]     oLoadData;

    int   tests = 0;
    int   fails = 0;
    acc_t expQ[$];

    mem_access_sequencer_if #(.ADDR_WIDTH(16)) dm();

    mem_access_sequencer #(.ADDR_WIDTH(16)) dut (
        .iClk        (iClk),
        .iResetN     (iResetN),
        .iValid      (iValid),
        .iMemControl (iMemControl),
        .iAddress    (iAddress),
        .iStoreData  (iStoreData),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oLoadData   (oLoadData),
        .dMem        (dm)
    );

    always #5 iClk = ~iClk;

    function automatic lc3b_mem_control mkCtrl(logic rd, logic wr, logic by, logic ind);
        lc3b_mem_control c;
        c.memRead    = rd;
        c.memWrite   = wr;
        c.dataMuxSel = 1'b0;
        c.byteEnable = by;
        c.indirect   = ind;
        return c;
    endfunction

    function automatic acc_t mkAcc(logic [15:0] addr, logic write, logic [1:0] be, logic [15:0] wdata,
                                   logic [15:0] rdata, int waits, logic isLast, logic [15:0] load);
        acc_t a;
        a.addr = addr; a.write = write; a.be = be; a.wdata = wdata;
        a.rdata = rdata; a.waits = waits; a.isLast = isLast; a.load = load;
        return a;
    endfunction

    // Entered at posedge+1 in IDLE; leaves at posedge+1 after the acceptance edge.
    task automatic issueOp(input lc3b_mem_control ctrl, input logic [15:0] addr, input logic [15:0] store);
        iValid = 1'b1; iMemControl = ctrl; iAddress = addr; iStoreData = store;
        @(negedge iClk);
        tests++;
        if (oBusy !== 1'b1 || dm.oDMemRead !== 1'b0 || dm.oDMemWrite !== 1'b0) begin
            fails++;
            $display("FAIL accept: busy=%b rd=%b wr=%b expected busy=1 rd=0 wr=0", oBusy, dm.oDMemRead, dm.oDMemWrite);
        end
        @(posedge iClk); #1;
        iValid = 1'b0; iMemControl = '0; iAddress = '0; iStoreData = '0;
    endtask

    // Pops each expected access, checks the request every cycle, answers after its wait count.
    task automatic drainAccesses(input string name);
        acc_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            for (int w = 0; w <= e.waits; w++) begin
                if (w == e.waits) begin
                    dm.iDMemResp = 1'b1; dm.iDMemRdata = e.rdata;
                end
                @(negedge iClk);
                tests++;
                if (dm.oDMemRead !== ~e.write || dm.oDMemWrite !== e.write || dm.oDMemAddr !== e.addr ||
                    dm.oDMemByteEn !== e.be || dm.oDMemWdata !== e.wdata) begin
                    fails++;
                    $display("FAIL %s req: rd=%b wr=%b addr=%h be=%b wdata=%h expected rd=%b wr=%b addr=%h be=%b wdata=%h",
                             name, dm.oDMemRead, dm.oDMemWrite, dm.oDMemAddr, dm.oDMemByteEn, dm.oDMemWdata,
                             ~e.write, e.write, e.addr, e.be, e.wdata);
                end
                tests++;
                if (w == e.waits && e.isLast) begin
                    if (oDone !== 1'b1 || oBusy !== 1'b0 || oLoadData !== e.load) begin
                        fails++;
                        $display("FAIL %s done: done=%b busy=%b load=%h expected done=1 busy=0 load=%h",
                                 name, oDone, oBusy, oLoadData, e.load);
                    end
                end else if (oDone !== 1'b0 || oBusy !== 1'b1 || oLoadData !== 16'h0) begin
                    fails++;
                    $display("FAIL %s wait: done=%b busy=%b load=%h expected done=0 busy=1 load=0000",
                             name, oDone, oBusy, oLoadData);
                end
                @(posedge iClk); #1;
                dm.iDMemResp = 1'b0; dm.iDMemRdata = '0;
            end
        end
    endtask

    task automatic idleCheck(input string name);
        @(negedge iClk);
        tests++;
        if (oDone !== 1'b0 || oBusy !== 1'b0 || dm.oDMemRead !== 1'b0 || dm.oDMemWrite !== 1'b0 ||
            dm.oDMemAddr !== 16'h0 || dm.oDMemWdata !== 16'h0 || dm.oDMemByteEn !== 2'b00 || oLoadData !== 16'h0) begin
            fails++;
            $display("FAIL %s idle: done=%b busy=%b rd=%b wr=%b addr=%h wdata=%h be=%b load=%h expected all 0",
                     name, oDone, oBusy, dm.oDMemRead, dm.oDMemWrite, dm.oDMemAddr, dm.oDMemWdata,
                     dm.oDMemByteEn, oLoadData);
        end
        @(posedge iClk); #1;
    endtask

    task automatic test_reset();
        iResetN = 1'b0; iValid = 1'b0; iMemControl = '0; iAddress = '0; iStoreData = '0;
        dm.iDMemResp = 1'b0; dm.iDMemRdata = '0;
        #12;
        idleCheck("reset");
        iResetN = 1'b1;
        idleCheck("post_reset");
    endtask

    task automatic test_word_load();
        issueOp(mkCtrl(1, 0, 0, 0), 16'h3004, 16'h0);
        expQ.push_back(mkAcc(16'h3004, 0, 2'b11, 16'h0, 16'hBEEF, 2, 1, 16'hBEEF));
        drainAccesses("ldr");
        idleCheck("ldr");
    endtask

    task automatic test_byte_store();
        issueOp(mkCtrl(0, 1, 1, 0), 16'h2001, 16'h12A5);
        expQ.push_back(mkAcc(16'h2001, 1, 2'b10, 16'hA5A5, 16'hFFFF, 0, 1, 16'h0));
        drainAccesses("stb");
    endtask

    task automatic test_byte_load();
        issueOp(mkCtrl(1, 0, 1, 0), 16'h2000, 16'h0);
        expQ.push_back(mkAcc(16'h2000, 0, 2'b01, 16'h0, 16'hC37E, 1, 1, 16'h007E));
        drainAccesses("ldb_lo");
        issueOp(mkCtrl(1, 0, 1, 0), 16'h2001, 16'h0);
        expQ.push_back(mkAcc(16'h2001, 0, 2'b10, 16'h0, 16'hC37E, 0, 1, 16'h00C3));
        drainAccesses("ldb_hi");
    endtask

    task automatic test_word_store_odd();
        issueOp(mkCtrl(0, 1, 0, 0), 16'h2003, 16'h1234);
        expQ.push_back(mkAcc(16'h2002, 1, 2'b11, 16'h1234, 16'h0, 1, 1, 16'h0));
        drainAccesses("str_odd");
    endtask

    task automatic test_indirect();
        issueOp(mkCtrl(1, 0, 0, 1), 16'h4000, 16'h0);
`ifdef MEM_SEQ_INDIRECT_EN
        expQ.push_back(mkAcc(16'h4000, 0, 2'b11, 16'h0, 16'h5003, 0, 0, 16'h0));
        expQ.push_back(mkAcc(16'h5002, 0, 2'b11, 16'h0, 16'h0042, 0, 1, 16'h0042));
`else
        expQ.push_back(mkAcc(16'h4000, 0, 2'b11, 16'h0, 16'h0042, 0, 1, 16'h0042));
`endif
        drainAccesses("ldi");
        idleCheck("ldi");
    endtask

    task automatic test_illegal_rw();
        issueOp(mkCtrl(1, 1, 0, 0), 16'h3000, 16'h9999);
        expQ.push_back(mkAcc(16'h3000, 0, 2'b11, 16'h0, 16'h1111, 0, 1, 16'h1111));
        drainAccesses("rw_both");
    endtask

    task automatic test_back_to_back();
        issueOp(mkCtrl(1, 0, 0, 0), 16'h0100, 16'h0);
        expQ.push_back(mkAcc(16'h0100, 0, 2'b11, 16'h0, 16'hAAAA, 0, 1, 16'hAAAA));
        drainAccesses("b2b_first");
        issueOp(mkCtrl(1, 0, 1, 0), 16'h0101, 16'h0);
        expQ.push_back(mkAcc(16'h0101, 0, 2'b10, 16'h0, 16'h55CC, 0, 1, 16'h0055));
        drainAccesses("b2b_second");
    endtask

    task automatic test_no_op();
        iValid = 1'b1; iMemControl = mkCtrl(0, 0, 1, 1); iAddress = 16'h7777; iStoreData = 16'h8888;
        for (int c = 0; c < 4; c++) begin
            dm.iDMemResp = (c == 2); dm.iDMemRdata = 16'hDEAD;
            @(negedge iClk);
            tests++;
            if (oBusy !== 1'b0 || oDone !== 1'b0 || dm.oDMemRead !== 1'b0 || dm.oDMemWrite !== 1'b0 ||
                oLoadData !== 16'h0) begin
                fails++;
                $display("FAIL no_op cycle %0d: busy=%b done=%b rd=%b wr=%b load=%h expected all 0",
                         c, oBusy, oDone, dm.oDMemRead, dm.oDMemWrite, oLoadData);
            end
            @(posedge iClk); #1;
        end
        iValid = 1'b0; iMemControl = '0; iAddress = '0; iStoreData = '0;
        dm.iDMemResp = 1'b0; dm.iDMemRdata = '0;
        issueOp(mkCtrl(1, 0, 0, 0), 16'h0200, 16'h0);
        expQ.push_back(mkAcc(16'h0200, 0, 2'b11, 16'h0, 16'h0F0F, 0, 1, 16'h0F0F));
        drainAccesses("after_no_op");
    endtask

    task automatic test_reset_mid();
        issueOp(mkCtrl(0, 1, 0, 1), 16'h4000, 16'h0777);
        @(negedge iClk);
        tests++;
`ifdef MEM_SEQ_INDIRECT_EN
        if (dm.oDMemRead !== 1'b1 || dm.oDMemAddr !== 16'h4000 || oBusy !== 1'b1) begin
            fails++;
            $display("FAIL sti_ptr: rd=%b addr=%h busy=%b expected rd=1 addr=4000 busy=1",
                     dm.oDMemRead, dm.oDMemAddr, oBusy);
        end
`else
        if (dm.oDMemWrite !== 1'b1 || dm.oDMemAddr !== 16'h4000 || dm.oDMemWdata !== 16'h0777) begin
            fails++;
            $display("FAIL sti_direct: wr=%b addr=%h wdata=%h expected wr=1 addr=4000 wdata=0777",
                     dm.oDMemWrite, dm.oDMemAddr, dm.oDMemWdata);
        end
`endif
        #2 iResetN = 1'b0;
        #1;
        tests++;
        if (oBusy !== 1'b0 || oDone !== 1'b0 || dm.oDMemRead !== 1'b0 || dm.oDMemWrite !== 1'b0 ||
            dm.oDMemAddr !== 16'h0 || dm.oDMemWdata !== 16'h0 || dm.oDMemByteEn !== 2'b00 || oLoadData !== 16'h0) begin
            fails++;
            $display("FAIL reset_abort: busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h be=%b load=%h expected all 0",
                     oBusy, oDone, dm.oDMemRead, dm.oDMemWrite, dm.oDMemAddr, dm.oDMemWdata,
                     dm.oDMemByteEn, oLoadData);
        end
        @(posedge iClk); #1;
        iResetN = 1'b1;
        idleCheck("after_abort");
        issueOp(mkCtrl(1, 0, 0, 0), 16'h3008, 16'h0);
        expQ.push_back(mkAcc(16'h3008, 0, 2'b11, 16'h0, 16'h0BAD, 1, 1, 16'h0BAD));
        drainAccesses("ldr_after_abort");
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_word_store_odd();
        test_indirect();
        test_illegal_rw();
        test_back_to_back();
        test_no_op();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
